// File: rtl/display_scan_ctrl_if.sv
// Display scan controller bus: scan enable, digit data/enables from the
// host side, multiplexed anode/segment drive and timing strobes back.
interface display_scan_ctrl_if;
    logic        en;
    logic [15:0] digit_val;
    logic [3:0]  digit_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  slot_o;
    logic        frame_o;
    logic        sample_o;

    modport master (
        output en, digit_val, digit_en,
        input  an, seg, slot_o, frame_o, sample_o
    );

    modport slave (
        input  en, digit_val, digit_en,
        output an, seg, slot_o, frame_o, sample_o
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// Each digit slot is BLANK_CYCLES of anti-ghost blanking followed by
// SLOT_CYCLES-BLANK_CYCLES of drive; digits are latched once per frame.
// Optional macro DISPLAY_LEADING_ZERO_BLANK_EN suppresses leading zeros.
module display_scan_ctrl #(
    parameter int unsigned SLOT_CYCLES  = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned SAMPLE_SLOTS = 500
) (
    input  logic               clk,
    input  logic               rst,
    display_scan_ctrl_if.slave bus
);

    localparam int unsigned CW = $clog2(SLOT_CYCLES + 1);
    localparam int unsigned SW = $clog2(SAMPLE_SLOTS + 1);

    localparam logic [CW-1:0] BLANK_LAST  = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST  = CW'(SLOT_CYCLES - BLANK_CYCLES - 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // With no guard time a slot starts directly in DRIVE.
    localparam state_t SLOT_ENTRY = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sample_cnt;
    logic [1:0]    slot;
    logic [15:0]   latched;

    logic [3:0]    cur_nib;
    logic [3:0]    drive_an;
    logic [3:0]    lz_hide;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    // A digit above 0 is hidden when it and every higher latched nibble are zero.
    always_comb begin
        lz_hide    = '0;
        lz_hide[3] = (latched[15:12] == 4'h0);
        lz_hide[2] = lz_hide[3] && (latched[11:8] == 4'h0);
        lz_hide[1] = lz_hide[2] && (latched[7:4] == 4'h0);
        lz_hide[0] = 1'b0;
    end
`else
    assign lz_hide = '0;
`endif

    // Anode/segment pattern for the current slot while driving.
    always_comb begin
        cur_nib  = latched[{slot, 2'b00} +: 4];
        drive_an = '1;
        if (bus.digit_en[slot] && !lz_hide[slot]) begin
            drive_an[slot] = 1'b0;
        end
    end

    // Scan FSM with slot/sample counters, frame latch and registered outputs.
    // Outputs are decoded from the state held before each edge, so they trail
    // the FSM by one cycle; frame_o and sample_o fire on the transition edge
    // itself, which keeps frame_o coincident with the digit latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sample_cnt   <= '0;
            slot         <= '0;
            latched      <= '0;
            bus.an       <= '1;
            bus.seg      <= '1;
            bus.slot_o   <= '0;
            bus.frame_o  <= 1'b0;
            bus.sample_o <= 1'b0;
        end else if (!bus.en) begin
            state        <= IDLE;
            cnt          <= '0;
            sample_cnt   <= '0;
            slot         <= '0;
            bus.an       <= '1;
            bus.seg      <= '1;
            bus.slot_o   <= '0;
            bus.frame_o  <= 1'b0;
            bus.sample_o <= 1'b0;
        end else begin
            bus.frame_o  <= 1'b0;
            bus.sample_o <= 1'b0;
            bus.slot_o   <= slot;

            if (state == DRIVE) begin
                bus.an  <= drive_an;
                bus.seg <= hex7(cur_nib);
            end else begin
                bus.an  <= '1;
                bus.seg <= '1;
            end

            case (state)
                IDLE: begin
                    state       <= SLOT_ENTRY;
                    cnt         <= '0;
                    sample_cnt  <= '0;
                    slot        <= '0;
                    latched     <= bus.digit_val;
                    bus.frame_o <= 1'b1;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        cnt   <= '0;
                        state <= DRIVE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        cnt   <= '0;
                        slot  <= slot + 2'd1;
                        state <= SLOT_ENTRY;
                        if (slot == 2'd3) begin
                            latched     <= bus.digit_val;
                            bus.frame_o <= 1'b1;
                        end
                        if (sample_cnt == SAMPLE_LAST) begin
                            sample_cnt   <= '0;
                            bus.sample_o <= 1'b1;
                        end else begin
                            sample_cnt <= sample_cnt + SW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with SLOT_CYCLES=8, BLANK_CYCLES=2,
// SAMPLE_SLOTS=3. Expected patterns follow DISPLAY_LEADING_ZERO_BLANK_EN.
module tb_display_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    display_scan_ctrl_if bus();

    display_scan_ctrl #(
        .SLOT_CYCLES (8),
        .BLANK_CYCLES(2),
        .SAMPLE_SLOTS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [15:0]     dval;
        logic [3:0]      den;
        logic [3:0][3:0] an_e;   // indexed by slot
        logic [3:0][6:0] seg_e;  // indexed by slot
    } vec_t;

    vec_t vt [6];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k     = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    // Drop en, load inputs, re-enable; on return k=0 is the enabling edge.
    task automatic restart(input logic [15:0] dv, input logic [3:0] de);
        bus.en = 1'b0;
        tick();
        tick();
        bus.digit_val = dv;
        bus.digit_en  = de;
        bus.en        = 1'b1;
        tick();
        k = 0;
    endtask

    initial begin
        vt[0].dval = 16'h1234; vt[0].den = 4'hF;
        vt[0].an_e  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        vt[0].seg_e = {7'h79, 7'h24, 7'h30, 7'h19};
        vt[1].dval = 16'hABCD; vt[1].den = 4'b0101;
        vt[1].an_e  = {4'b1111, 4'b1011, 4'b1111, 4'b1110};
        vt[1].seg_e = {7'h08, 7'h03, 7'h46, 7'h21};
        vt[2].dval = 16'hEF90; vt[2].den = 4'hF;
        vt[2].an_e  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        vt[2].seg_e = {7'h06, 7'h0E, 7'h10, 7'h40};
        vt[3].dval = 16'h0007; vt[3].den = 4'hF;
        vt[3].seg_e = {7'h40, 7'h40, 7'h40, 7'h78};
        vt[4].dval = 16'h0506; vt[4].den = 4'hF;
        vt[4].seg_e = {7'h40, 7'h12, 7'h40, 7'h02};
        vt[5].dval = 16'h0000; vt[5].den = 4'b1110;
        vt[5].seg_e = {7'h40, 7'h40, 7'h40, 7'h40};
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
        vt[3].an_e = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
        vt[4].an_e = {4'b1111, 4'b1011, 4'b1101, 4'b1110};
        vt[5].an_e = {4'b1111, 4'b1111, 4'b1111, 4'b1111};
`else
        vt[3].an_e = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        vt[4].an_e = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        vt[5].an_e = {4'b0111, 4'b1011, 4'b1101, 4'b1111};
`endif

        bus.en        = 1'b0;
        bus.digit_val = 16'h0000;
        bus.digit_en  = 4'h0;

        // Reset state.
        #12;
        chk("reset_an",     {12'h0, bus.an},     16'h000F);
        chk("reset_seg",    {9'h0, bus.seg},     16'h007F);
        chk("reset_slot",   {14'h0, bus.slot_o}, 16'h0000);
        chk("reset_frame",  {15'h0, bus.frame_o},  16'h0000);
        chk("reset_sample", {15'h0, bus.sample_o}, 16'h0000);
        rst = 1'b1;

        // Table: one full frame per vector.
        for (int v = 0; v < 6; v++) begin
            restart(vt[v].dval, vt[v].den);
            chk($sformatf("v%0d_frame0", v), {15'h0, bus.frame_o}, 16'h0001);
            while (k < 32) begin
                tick();
                for (int s = 0; s < 4; s++) begin
                    if (k == 8 * s + 1) begin
                        chk($sformatf("v%0d_s%0d_blank_an", v, s), {12'h0, bus.an}, 16'h000F);
                    end
                    if (k == 8 * s + 5) begin
                        chk($sformatf("v%0d_s%0d_an", v, s), {12'h0, bus.an}, {12'h0, vt[v].an_e[s]});
                        chk($sformatf("v%0d_s%0d_seg", v, s), {9'h0, bus.seg}, {9'h0, vt[v].seg_e[s]});
                        chk($sformatf("v%0d_s%0d_slot", v, s), {14'h0, bus.slot_o}, 16'(s));
                    end
                end
            end
            chk($sformatf("v%0d_frame32", v), {15'h0, bus.frame_o}, 16'h0001);
        end

        // Mid-frame digit change must not tear the current frame.
        restart(16'h1234, 4'hF);
        while (k < 61) begin
            tick();
            if (k == 18) bus.digit_val = 16'h5678;
            if (k == 21) chk("tear_s2_seg", {9'h0, bus.seg}, 16'h0024);
            if (k == 29) chk("tear_s3_seg", {9'h0, bus.seg}, 16'h0079);
            if (k == 37) chk("next_s0_seg", {9'h0, bus.seg}, 16'h0000);
            if (k == 45) chk("next_s1_seg", {9'h0, bus.seg}, 16'h0078);
            if (k == 53) chk("next_s2_seg", {9'h0, bus.seg}, 16'h0002);
            if (k == 61) chk("next_s3_seg", {9'h0, bus.seg}, 16'h0012);
        end

        // Sample and frame strobe positions with en held high.
        restart(16'h1234, 4'hF);
        while (k < 60) begin
            tick();
            chk($sformatf("sample_k%0d", k), {15'h0, bus.sample_o}, 16'((k % 24) == 0));
            chk($sformatf("frame_k%0d", k),  {15'h0, bus.frame_o},  16'((k % 32) == 0));
        end
        // Disable for 5 cycles mid-count, then restart.
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("off_an_%0d", i),     {12'h0, bus.an},       16'h000F);
            chk($sformatf("off_sample_%0d", i), {15'h0, bus.sample_o}, 16'h0000);
        end
        bus.en = 1'b1;
        tick();
        k = 0;
        chk("reen_frame", {15'h0, bus.frame_o}, 16'h0001);
        while (k < 30) begin
            tick();
            chk($sformatf("reen_sample_k%0d", k), {15'h0, bus.sample_o}, 16'(k == 24));
        end

        // Asynchronous reset mid-DRIVE blanks before the next edge.
        restart(16'h1234, 4'hF);
        while (k < 5) tick();
        chk("pre_rst_an", {12'h0, bus.an}, 16'h000E);
        #2;
        rst = 1'b0;
        #1;
        chk("async_an",     {12'h0, bus.an},       16'h000F);
        chk("async_seg",    {9'h0, bus.seg},       16'h007F);
        chk("async_sample", {15'h0, bus.sample_o}, 16'h0000);
        chk("async_slot",   {14'h0, bus.slot_o},   16'h0000);
        rst = 1'b1;
        tick();
        chk("post_rst_frame", {15'h0, bus.frame_o}, 16'h0001);
        chk("post_rst_slot",  {14'h0, bus.slot_o},  16'h0000);
        while (k < 9) tick();
        chk("post_rst_s0_an", {12'h0, bus.an}, 16'h000E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter SLOT_CYCLES, default 50000; clock cycles per digit slot (1 ms at 50 MHz).
REQ-002 Parameter BLANK_CYCLES, default 500; anti-ghost guard cycles at slot start; SHALL satisfy 0 <= BLANK_CYCLES < SLOT_CYCLES.
REQ-003 Parameter SAMPLE_SLOTS, default 500; slots per sample strobe (500 ms).
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 en  in  1  scan enable; 0 blanks the display and halts the counters.
REQ-007 digit_val  in  16  four BCD/hex nibbles; [3:0] is digit 0 (rightmost).
REQ-008 digit_en  in  4  per-digit enable; bit i gates anode i.
REQ-009 an  out  4  anodes, active-low; bit i drives digit i.
REQ-010 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 slot_o  out  2  index of the current slot.
REQ-012 frame_o  out  1  one-cycle pulse at the start of slot 0.
REQ-013 sample_o  out  1  one-cycle load strobe for the input register.

Function
REQ-014 FSM states: IDLE, BLANK, DRIVE.
REQ-015 IDLE: an=4'b1111, seg=7'h7F; when en=1, go to BLANK with slot=0 on the next cycle.
REQ-016 BLANK: lasts BLANK_CYCLES cycles with an=4'b1111, then goes to DRIVE; BLANK_CYCLES=0 skips BLANK entirely.
REQ-017 DRIVE: lasts SLOT_CYCLES-BLANK_CYCLES cycles.
REQ-018 During DRIVE, an[slot]=0 if digit_en[slot]=1, all other anodes=1, and seg=hex decode of the latched nibble[slot].
REQ-019 At the end of DRIVE, slot increments modulo 4 (3 wraps to 0) and the FSM enters BLANK.
REQ-020 A slot with digit_en=0 SHALL still consume its full slot time, with anodes high; frame period is fixed at 4*SLOT_CYCLES.
REQ-021 digit_val SHALL be latched only on slot-0 entry, the same cycle frame_o pulses; mid-frame changes appear in the next frame (no tearing).
REQ-022 Hex decode, active-low {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-023 sample_o SHALL pulse for one cycle at the end of every SAMPLE_SLOTS-th completed slot; its slot counter wraps to 0 on the pulse.
REQ-024 en falling in any state SHALL force IDLE on the next edge; outputs blank and all counters clear.
REQ-025 Re-enable SHALL restart at slot 0 with frame_o, and SHALL NOT produce a spurious sample_o.
REQ-026 an, seg, slot_o, frame_o, sample_o SHALL all be registered outputs, updating one cycle after the FSM or counter change that selects them.

Reset
REQ-027 rst=0 asynchronously forces: state=IDLE, an=4'b1111, seg=7'h7F, slot_o=0, frame_o=0, sample_o=0, all counters=0, latched digits=16'h0000.
REQ-028 Reset asserted mid-slot SHALL blank outputs in the same cycle, without waiting for a clock edge; after release, operation resumes per REQ-015.

Configuration
REQ-029 Macro DISPLAY_LEADING_ZERO_BLANK_EN.
REQ-030 Macro defined: digit i (i>0) is suppressed (anode high) when its latched nibble and all higher nibbles are 0; digit 0 is always shown if enabled.
REQ-031 Macro undefined: every enabled digit is driven, including leading zeros.

Verification (SLOT_CYCLES=8, BLANK_CYCLES=2, SAMPLE_SLOTS=3)
REQ-032 Drop rst mid-DRIVE -> an=1111 and seg=7F before the next edge; sample_o=0; after release with en=1, slot_o=0 and frame_o pulses.
REQ-033 digit_val=16'h1234, digit_en=F -> per slot: 2 cycles an=1111, then 6 cycles of an=1110/seg=19, 1101/30, 1011/24, 0111/79; frame_o every 32 cycles.
REQ-034 Change digit_val to 16'h5678 during slot 2 -> slots 2-3 still show 2 and 1; next frame shows 8,7,6,5.
REQ-035 en held 1 -> sample_o pulses once every 24 cycles; drop en for 5 cycles and restore -> first pulse 24 cycles after the restart.
REQ-036 digit_val=16'h0007, digit_en=F -> macro defined: only an[0] goes low, seg=78; macro undefined: all four anodes go low, showing 0,0,0,7.
